// File: rtl/gcd_unit_param.sv
// Width-parametrised subtract-and-swap GCD engine with valid/ready request and response channels.
// Optional per-request CALC cycle counter on cycles_o when GCD_CYCLE_CNT_EN is defined.
module gcd_unit_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH + 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
`ifdef GCD_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] cycles_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;

`ifdef GCD_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] cnt_inc;

  // The count includes the current CALC cycle, so the latched value covers the final B==0 cycle.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`endif

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
`ifdef GCD_CYCLE_CNT_EN
    cnt_d        = cnt_q;
    cycles_d     = cycles_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
`ifdef GCD_CYCLE_CNT_EN
          cnt_d   = '0;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
`ifdef GCD_CYCLE_CNT_EN
        cnt_d = cnt_inc;
`endif
        if (b_q == '0) begin
          result_d = a_q;
`ifdef GCD_CYCLE_CNT_EN
          cycles_d = cnt_inc;
`endif
          state_d  = DONE;
        end else if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else begin
          a_d = a_q - b_q;
        end
      end
      DONE: begin
        if (resp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are decoded from the next state so they come straight out of flops.
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == DONE);
    busy_d       = (state_d == CALC) || (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef GCD_CYCLE_CNT_EN
      cnt_q        <= '0;
      cycles_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
`ifdef GCD_CYCLE_CNT_EN
      cnt_q        <= cnt_d;
      cycles_q     <= cycles_d;
`endif
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign result_o     = result_q;
  assign busy_o       = busy_q;
`ifdef GCD_CYCLE_CNT_EN
  assign cycles_o     = cycles_q;
`endif

endmodule

// File: tb/tb_gcd_unit_param.sv
// Directed scoreboard bench for gcd_unit_param: 16-bit unit plus 8-bit units for the long/saturating case.
// Cycle-count checks are compiled in only when GCD_CYCLE_CNT_EN is defined.
module tb_gcd_unit_param;

  logic        clk_i;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [15:0] result_o;
  logic        busy_o;

  logic        r8_valid;
  logic        r8_ready;
  logic [7:0]  r8_a;
  logic [7:0]  r8_b;
  logic        p8_valid;
  logic        p8_ready;
  logic [7:0]  p8_result;
  logic        p8_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];

`ifdef GCD_CYCLE_CNT_EN
  logic [17:0] cycles_o;
  logic [9:0]  p8_cycles;
  logic        s8_ready;
  logic        s8_valid;
  logic [7:0]  s8_result;
  logic        s8_busy;
  logic [3:0]  s8_cycles;
`endif

  gcd_unit_param #(.WIDTH(16)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .result_o    (result_o),
    .busy_o      (busy_o)
`ifdef GCD_CYCLE_CNT_EN
    ,
    .cycles_o    (cycles_o)
`endif
  );

  gcd_unit_param #(.WIDTH(8)) dut8 (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (r8_valid),
    .req_ready_o (r8_ready),
    .a_i         (r8_a),
    .b_i         (r8_b),
    .resp_valid_o(p8_valid),
    .resp_ready_i(p8_ready),
    .result_o    (p8_result),
    .busy_o      (p8_busy)
`ifdef GCD_CYCLE_CNT_EN
    ,
    .cycles_o    (p8_cycles)
`endif
  );

`ifdef GCD_CYCLE_CNT_EN
  gcd_unit_param #(.WIDTH(8), .CNT_W(4)) dut8s (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (r8_valid),
    .req_ready_o (s8_ready),
    .a_i         (r8_a),
    .b_i         (r8_b),
    .resp_valid_o(s8_valid),
    .resp_ready_i(p8_ready),
    .result_o    (s8_result),
    .busy_o      (s8_busy),
    .cycles_o    (s8_cycles)
  );
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents one request on the 16-bit unit and returns at the negedge right after it is accepted.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] exp_res, input int exp_cyc, input bit expect_resp);
    int n;
    exp_t e;
    if (expect_resp) begin
      e.res = exp_res;
      e.cyc = exp_cyc;
      sb_q.push_back(e);
    end
    @(negedge clk_i);
    a_i = a;
    b_i = b;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 20) checkOutput("req_accept_timeout", 32'(n), 32'(0));
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Waits for the response, optionally stalls it, compares against the scoreboard and completes it.
  task automatic collectResponse(input string tag, input int max_cycles, input int exp_latency, input int stall);
    int   k;
    exp_t e;
    k = 0;
    while (!resp_valid_o && k < max_cycles) begin
      @(negedge clk_i);
      k++;
    end
    checkOutput({tag, "_resp_seen"}, 32'(resp_valid_o), 32'(1));
    if (exp_latency > 0) checkOutput({tag, "_latency"}, 32'(k + 1), 32'(exp_latency));
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_scoreboard_empty"}, 32'(0), 32'(1));
      return;
    end
    e = sb_q.pop_front();
    checkOutput({tag, "_result"}, 32'(result_o), 32'(e.res));
`ifdef GCD_CYCLE_CNT_EN
    checkOutput({tag, "_cycles"}, 32'(cycles_o), 32'(e.cyc));
`endif
    checkOutput({tag, "_busy_done"}, 32'(busy_o), 32'(1));
    for (int s = 0; s < stall; s++) begin
      req_valid_i = s[0];
      a_i = 16'd100;
      b_i = 16'd50;
      @(negedge clk_i);
      checkOutput({tag, "_stall_valid"}, 32'(resp_valid_o), 32'(1));
      checkOutput({tag, "_stall_result"}, 32'(result_o), 32'(e.res));
      checkOutput({tag, "_stall_ready"}, 32'(req_ready_o), 32'(0));
    end
    req_valid_i = 1'b0;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput({tag, "_valid_after_hs"}, 32'(resp_valid_o), 32'(0));
    checkOutput({tag, "_ready_after_hs"}, 32'(req_ready_o), 32'(1));
    checkOutput({tag, "_result_held"}, 32'(result_o), 32'(e.res));
  endtask

  initial begin
    int n;
    int seen;
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    a_i = '0;
    b_i = '0;
    resp_ready_i = 1'b1;
    r8_valid = 1'b0;
    r8_a = '0;
    r8_b = '0;
    p8_ready = 1'b1;

    repeat (3) @(negedge clk_i);
    checkOutput("reset_req_ready", 32'(req_ready_o), 32'(1));
    checkOutput("reset_resp_valid", 32'(resp_valid_o), 32'(0));
    checkOutput("reset_busy", 32'(busy_o), 32'(0));
    checkOutput("reset_result", 32'(result_o), 32'(0));
`ifdef GCD_CYCLE_CNT_EN
    checkOutput("reset_cycles", 32'(cycles_o), 32'(0));
`endif
    rst_ni = 1'b1;

    applyStimulus(16'd12, 16'd8, 16'd4, 6, 1'b1);
    checkOutput("g12_8_busy_calc", 32'(busy_o), 32'(1));
    checkOutput("g12_8_not_ready", 32'(req_ready_o), 32'(0));
    collectResponse("g12_8", 50, 7, 0);

    applyStimulus(16'd0, 16'd0, 16'd0, 1, 1'b1);
    collectResponse("g0_0", 50, 2, 0);
    applyStimulus(16'd7, 16'd0, 16'd7, 1, 1'b1);
    collectResponse("g7_0", 50, 2, 0);
    applyStimulus(16'd0, 16'd5, 16'd5, 2, 1'b1);
    collectResponse("g0_5", 50, 3, 0);
    applyStimulus(16'd17, 16'd5, 16'd1, 11, 1'b1);
    collectResponse("g17_5", 50, 12, 0);
    applyStimulus(16'd8, 16'd12, 16'd4, 7, 1'b1);
    collectResponse("g8_12", 50, 8, 0);

    // Back-pressure with ignored request pulses during the stall.
    resp_ready_i = 1'b0;
    applyStimulus(16'd21, 16'd14, 16'd7, 6, 1'b1);
    collectResponse("g21_14_bp", 50, 7, 10);
    @(negedge clk_i);
    checkOutput("bp_no_spurious_busy", 32'(busy_o), 32'(0));
    checkOutput("bp_result_still_held", 32'(result_o), 32'(7));

    // Reset in the middle of a long calculation must drop the request silently.
    applyStimulus(16'd255, 16'd1, 16'd0, 0, 1'b0);
    repeat (5) @(negedge clk_i);
    checkOutput("midrst_busy_before", 32'(busy_o), 32'(1));
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy_o), 32'(0));
    checkOutput("midrst_ready", 32'(req_ready_o), 32'(1));
    checkOutput("midrst_result", 32'(result_o), 32'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (resp_valid_o) seen++;
    end
    checkOutput("midrst_no_resp", 32'(seen), 32'(0));
    applyStimulus(16'd9, 16'd6, 16'd3, 6, 1'b1);
    collectResponse("g9_6", 50, 7, 0);

    // 8-bit units: longest-running pair, with and without counter saturation.
    @(negedge clk_i);
    r8_a = 8'd255;
    r8_b = 8'd1;
    r8_valid = 1'b1;
    checkOutput("w8_ready", 32'(r8_ready), 32'(1));
    @(posedge clk_i);
    @(negedge clk_i);
    r8_valid = 1'b0;
    n = 0;
    while (!p8_valid && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("w8_resp_seen", 32'(p8_valid), 32'(1));
    checkOutput("w8_latency", 32'(n + 1), 32'(258));
    checkOutput("w8_result", 32'(p8_result), 32'(1));
`ifdef GCD_CYCLE_CNT_EN
    checkOutput("w8_cycles", 32'(p8_cycles), 32'(257));
    checkOutput("w8s_valid", 32'(s8_valid), 32'(1));
    checkOutput("w8s_result", 32'(s8_result), 32'(1));
    checkOutput("w8s_cycles_sat", 32'(s8_cycles), 32'(15));
`endif
    @(negedge clk_i);
    checkOutput("w8_idle_after", 32'(p8_busy), 32'(0));

    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
